// File: rtl/mem_seq_pkg.sv
// Shared definitions for the Hmmm memory-access sequencer: bus defaults and state encodings.
package mem_seq_pkg;

    localparam int HMMM_ADDR_W = 8;
    localparam int HMMM_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WRITE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_READ  = 3'd4,
        ST_DONE  = 3'd5
    } mem_seq_state_e;

endpackage

// File: rtl/mem_seq.sv
// Memory-access sequencer: drives the shared bus and the mar_in/mdr_in/mdr_out strobes for one
// load or store at a time, skipping the MAR phase when MAR already holds the requested address.
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W    = HMMM_ADDR_W,
    parameter int DATA_W    = HMMM_DATA_W,
    parameter int READ_WAIT = 1,
    parameter int SKIP_MAR  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              mar_in,
    output logic              mdr_in,
    output logic              mdr_out
);

    if (READ_WAIT < 0 || READ_WAIT > 3) begin : g_bad_read_wait
        $error("mem_seq: READ_WAIT must be in 0..3");
    end
    if (ADDR_W > DATA_W) begin : g_bad_addr_w
        $error("mem_seq: ADDR_W must not exceed DATA_W");
    end

    localparam logic [1:0] WAIT_LAST = (READ_WAIT > 0) ? 2'(READ_WAIT - 1) : 2'd0;

    mem_seq_state_e    state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] shadow_q;
    logic              shadow_vld_q;
    logic [1:0]        wait_cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              accept;
    logic              skip_addr;

    // Where a request goes once the address is in MAR (or already was).
    function automatic mem_seq_state_e after_addr(input logic we);
        if (we)
            return ST_WRITE;
        else if (READ_WAIT == 0)
            return ST_READ;
        else
            return ST_WAIT;
    endfunction

    assign accept    = req_valid && (state_q == ST_IDLE);
    assign skip_addr = (SKIP_MAR != 0) && shadow_vld_q && (shadow_q == req_addr);

    // State register and control state; rst only touches control and the response word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shadow_vld_q <= 1'b0;
            wait_cnt_q   <= 2'd0;
            rdata_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= (state_q == ST_WAIT) ? wait_cnt_q + 2'd1 : 2'd0;
            if (state_q == ST_ADDR)
                shadow_vld_q <= 1'b1;
            if (state_q == ST_READ)
                rdata_q <= bus_in;
        end
    end

    // Request capture and MAR shadow address.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
        if (state_q == ST_ADDR)
            shadow_q <= addr_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = skip_addr ? after_addr(req_we) : ST_ADDR;
            ST_ADDR:  state_d = after_addr(we_q);
            ST_WRITE: state_d = ST_DONE;
            ST_WAIT:  if (wait_cnt_q == WAIT_LAST) state_d = ST_READ;
            ST_READ:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decode only registered state and captured data.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        bus_oe    = 1'b0;
        bus_out   = '0;
        mar_in    = 1'b0;
        mdr_in    = 1'b0;
        mdr_out   = 1'b0;
        case (state_q)
            ST_IDLE:  req_ready = 1'b1;
            ST_ADDR: begin
                bus_oe  = 1'b1;
                bus_out = DATA_W'(addr_q);
                mar_in  = 1'b1;
            end
            ST_WRITE: begin
                bus_oe  = 1'b1;
                bus_out = wdata_q;
                mdr_in  = 1'b1;
            end
            ST_READ:  mdr_out   = 1'b1;
            ST_DONE:  rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq with a behavioural MAR/RAM/MDR behind a tri-state bus.
module tb_mem_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [15:0] bus_out;
    logic        bus_oe;
    logic        mar_in;
    logic        mdr_in;
    logic        mdr_out;
    wire  [15:0] bus;

    logic [7:0]  mar_q;
    logic [15:0] mdr_q;
    logic [15:0] ram [256];

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    logic rsp_prev = 1'b0;

    mem_seq #(.ADDR_W(8), .DATA_W(16), .READ_WAIT(1), .SKIP_MAR(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .bus_in    (bus),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .mdr_out   (mdr_out)
    );

    assign bus = bus_oe ? bus_out : (mdr_out ? mdr_q : 16'hzzzz);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    end

    // MAR, synchronous RAM and MDR; MDR follows RAM[MAR] unless being written from the bus.
    always @(posedge clk) begin
        if (mar_in) mar_q <= bus[7:0];
        if (mdr_in) begin
            ram[mar_q] <= bus;
            mdr_q      <= bus;
        end else begin
            mdr_q <= ram[mar_q];
        end
    end

    always @(posedge clk) begin
        if (!rst && req_valid && req_ready) acc_cnt++;
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks += 3;
            assert (!(bus_oe && mdr_out)) else begin
                errors++;
                $error("FAIL bus_excl: bus_oe=%0b mdr_out=%0b required not both high", bus_oe, mdr_out);
            end
            assert (!(mar_in && mdr_in)) else begin
                errors++;
                $error("FAIL strobe_excl: mar_in=%0b mdr_in=%0b required not both high", mar_in, mdr_in);
            end
            assert (!(rsp_valid && rsp_prev)) else begin
                errors++;
                $error("FAIL rsp_width: rsp_valid high two cycles running, required one-cycle pulse");
            end
        end
        rsp_prev <= rsp_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h required=%0h", tag, obs, expv);
        end
    endtask

    // Issue one request from an IDLE negedge and follow it to rsp_valid; returns at the next IDLE negedge.
    task automatic txn(input string tag, input logic we, input logic [7:0] a, input logic [15:0] d,
                       input int exp_lat, input logic exp_mar, input logic [15:0] exp_rd,
                       input logic hold);
        int   lat;
        logic saw_mar;
        logic got;
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        lat       = 0;
        saw_mar   = 1'b0;
        got       = 1'b0;
        while (!got && lat < 12) begin
            @(negedge clk);
            lat++;
            if (!hold) begin
                req_valid = 1'b0;
                req_addr  = ~a;
                req_wdata = ~d;
            end
            if (lat == 1) chk({tag, ".busy"}, {31'd0, req_ready}, 32'd0);
            if (mar_in) begin
                saw_mar = 1'b1;
                chk({tag, ".mar_bus"}, {16'd0, bus}, {24'd0, a});
            end
            if (mdr_in) chk({tag, ".mdr_bus"}, {16'd0, bus}, {16'd0, d});
            if (rsp_valid) got = 1'b1;
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".mar_phase"}, {31'd0, saw_mar}, {31'd0, exp_mar});
        chk({tag, ".rdata"}, {16'd0, rsp_rdata}, {16'd0, exp_rd});
        @(negedge clk);
    endtask

    initial begin
        int acc_base;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'd0;
        req_wdata = 16'd0;
        repeat (2) @(negedge clk);
        chk("reset.req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset.rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("reset.bus_oe",    {31'd0, bus_oe},    32'd0);
        chk("reset.bus_out",   {16'd0, bus_out},   32'd0);
        chk("reset.strobes",   {29'd0, mar_in, mdr_in, mdr_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        txn("st42", 1'b1, 8'd42, 16'd21, 3, 1'b1, 16'd0, 1'b0);
        txn("ld42", 1'b0, 8'd42, 16'd0,  3, 1'b0, 16'd21, 1'b0);

        txn("st32", 1'b1, 8'd32, 16'd24, 3, 1'b1, 16'd21, 1'b0);
        txn("st33", 1'b1, 8'd33, 16'd25, 3, 1'b1, 16'd21, 1'b0);
        txn("ld32", 1'b0, 8'd32, 16'd0,  4, 1'b1, 16'd24, 1'b0);
        txn("ld33", 1'b0, 8'd33, 16'd0,  4, 1'b1, 16'd25, 1'b0);

        txn("ld100", 1'b0, 8'd100, 16'd0, 4, 1'b1, 16'd0, 1'b0);

        acc_base = acc_cnt;
        txn("st0",   1'b1, 8'd0,   16'hFFFF, 3, 1'b1, 16'd0,    1'b1);
        txn("st255", 1'b1, 8'd255, 16'h0001, 3, 1'b1, 16'd0,    1'b1);
        txn("ld0",   1'b0, 8'd0,   16'd0,    4, 1'b1, 16'hFFFF, 1'b1);
        txn("ld255", 1'b0, 8'd255, 16'd0,    4, 1'b1, 16'h0001, 1'b1);
        req_valid = 1'b0;
        chk("hold.accepts", acc_cnt - acc_base, 4);

        txn("st7", 1'b1, 8'd7, 16'h1234, 3, 1'b1, 16'h0001, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'd7;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort.skip_mar", {31'd0, mar_in}, 32'd0);
        @(negedge clk);
        chk("abort.in_read", {31'd0, mdr_out}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.idle",      {31'd0, req_ready}, 32'd1);
        chk("abort.strobes",   {28'd0, mar_in, mdr_in, mdr_out, bus_oe}, 32'd0);
        chk("abort.no_rsp",    {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("abort.no_rsp_late", {31'd0, rsp_valid}, 32'd0);
        txn("ld7", 1'b0, 8'd7, 16'd0, 4, 1'b1, 16'h1234, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
